// File: rtl/serial_word_collector.sv
// Serial word collector: gathers an LSB-first bit stream into WIDTH-bit words,
// delimited by a start-of-frame marker, and hands each word to a single-entry
// valid/ready output slot. Framing and overrun errors are sticky flags.

module serial_word_collector #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_bit_valid,
   input  logic             i_bit_in,
   input  logic             i_sof,
   output logic [WIDTH-1:0] o_word_data,
   output logic             o_word_valid,
   input  logic             i_word_ready,
   input  logic             i_err_clr,
   output logic             o_overrun,
   output logic             o_frame_err
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_COLLECT = 1'b1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [0:0]       r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_word_data;
   logic             r_word_valid;
   logic             r_overrun;
   logic             r_frame_err;

   logic [0:0]       w_state_d;
   logic [CW-1:0]    w_count_d;
   logic [WIDTH-1:0] w_shift_d;
   logic [WIDTH-1:0] w_word;
   logic             w_complete;
   logic             w_frame_evt;
   logic             w_slot_free;
   logic             w_overrun_evt;
   logic [WIDTH-1:0] w_word_data_d;
   logic             w_word_valid_d;

   // Collector FSM next state: bit placement, word completion, framing error.
   always_comb begin
      w_state_d   = r_state;
      w_count_d   = r_count;
      w_shift_d   = r_shift;
      w_word      = r_shift;
      w_complete  = 1'b0;
      w_frame_evt = 1'b0;
      if (i_bit_valid) begin
         if (i_sof) begin
            // A new word always restarts at bit 0; an unfinished one is a framing error.
            w_frame_evt = (r_state == ST_COLLECT);
            w_shift_d   = {{(WIDTH-1){1'b0}}, i_bit_in};
            w_count_d   = CNT_ONE;
            w_state_d   = ST_COLLECT;
         end else if (r_state == ST_COLLECT) begin
            w_word[r_count] = i_bit_in;
            w_shift_d       = w_word;
            if (r_count == CNT_LAST) begin
               w_complete = 1'b1;
               w_count_d  = '0;
               w_state_d  = ST_IDLE;
            end else begin
               w_count_d = r_count + CNT_ONE;
            end
         end
      end
   end

   // Output slot next state: load on completion if free, else flag overrun.
   always_comb begin
      w_slot_free    = !r_word_valid || i_word_ready;
      w_word_data_d  = r_word_data;
      w_word_valid_d = r_word_valid && !i_word_ready;
      w_overrun_evt  = 1'b0;
      if (w_complete) begin
         if (w_slot_free) begin
            w_word_data_d  = w_word;
            w_word_valid_d = 1'b1;
         end else begin
            w_word_valid_d = 1'b1;
            w_overrun_evt  = 1'b1;
         end
      end
   end

   // State registers; error flags give set priority over clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_shift      <= '0;
         r_word_data  <= '0;
         r_word_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_count      <= w_count_d;
         r_shift      <= w_shift_d;
         r_word_data  <= w_word_data_d;
         r_word_valid <= w_word_valid_d;
         r_overrun    <= w_overrun_evt || (r_overrun && !i_err_clr);
         r_frame_err  <= w_frame_evt || (r_frame_err && !i_err_clr);
      end
   end

   assign o_word_data  = r_word_data;
   assign o_word_valid = r_word_valid;
   assign o_overrun    = r_overrun;
   assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector (WIDTH = 8).

module tb_serial_word_collector;

   logic       clk;
   logic       reset;
   logic       bit_valid;
   logic       bit_in;
   logic       sof;
   logic [7:0] word_data;
   logic       word_valid;
   logic       word_ready;
   logic       err_clr;
   logic       overrun;
   logic       frame_err;

   int n_total;
   int n_pass;

   serial_word_collector #(.WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_bit_valid  (bit_valid),
      .i_bit_in     (bit_in),
      .i_sof        (sof),
      .o_word_data  (word_data),
      .o_word_valid (word_valid),
      .i_word_ready (word_ready),
      .i_err_clr    (err_clr),
      .o_overrun    (overrun),
      .o_frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Send bits first..last of w; sof on bit 0; gap idle cycles after each non-final bit.
   task automatic send_bits(input logic [7:0] w, input int first, input int last,
                            input int gap);
      for (int i = first; i <= last; i++) begin
         bit_valid = 1'b1;
         sof       = (i == 0);
         bit_in    = w[i];
         step();
         bit_valid = 1'b0;
         sof       = 1'b0;
         bit_in    = 1'b0;
         if (i < last) repeat (gap) step();
      end
   endtask

   initial begin
      n_total    = 0;
      n_pass     = 0;
      reset      = 1'b1;
      bit_valid  = 1'b0;
      bit_in     = 1'b0;
      sof        = 1'b0;
      word_ready = 1'b0;
      err_clr    = 1'b0;
      step();
      step();
      check("rst_data", word_data, 0);
      check("rst_valid", word_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_err", frame_err, 0);
      reset = 1'b0;

      // Basic word
      word_ready = 1'b1;
      send_bits(8'hA5, 0, 7, 0);
      check("basic_valid", word_valid, 1);
      check("basic_data", word_data, 8'hA5);
      check("basic_overrun", overrun, 0);
      check("basic_frame_err", frame_err, 0);
      step();
      check("basic_valid_one_cycle", word_valid, 0);
      check("basic_data_hold", word_data, 8'hA5);

      // Gapped input
      send_bits(8'hA5, 0, 6, 3);
      repeat (3) step();
      check("gap_not_yet_valid", word_valid, 0);
      send_bits(8'hA5, 7, 7, 0);
      check("gap_valid", word_valid, 1);
      check("gap_data", word_data, 8'hA5);
      step();
      check("gap_valid_drop", word_valid, 0);

      // Backpressure and overrun
      word_ready = 1'b0;
      send_bits(8'h3C, 0, 7, 0);
      check("bp_first_valid", word_valid, 1);
      check("bp_first_data", word_data, 8'h3C);
      check("bp_first_overrun", overrun, 0);
      send_bits(8'hFF, 0, 7, 0);
      check("bp_hold_data", word_data, 8'h3C);
      check("bp_hold_valid", word_valid, 1);
      check("bp_overrun", overrun, 1);
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      check("bp_accept_valid", word_valid, 0);
      check("bp_accept_data", word_data, 8'h3C);
      check("bp_overrun_sticky", overrun, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("bp_overrun_clr", overrun, 0);

      // Frame error
      word_ready = 1'b1;
      send_bits(8'h0F, 0, 3, 0);
      check("fe_before", frame_err, 0);
      send_bits(8'h1E, 0, 0, 0);
      check("fe_set", frame_err, 1);
      check("fe_no_partial", word_valid, 0);
      send_bits(8'h1E, 1, 7, 0);
      check("fe_valid", word_valid, 1);
      check("fe_data", word_data, 8'h1E);
      step();
      // Clear coinciding with a new framing error: set wins
      send_bits(8'hFF, 0, 1, 0);
      err_clr = 1'b1;
      send_bits(8'h00, 0, 0, 0);
      err_clr = 1'b0;
      check("fe_set_wins", frame_err, 1);
      send_bits(8'h00, 1, 7, 0);
      check("fe2_data", word_data, 8'h00);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("fe_clr", frame_err, 0);

      // Simultaneous accept and completion
      word_ready = 1'b0;
      send_bits(8'h12, 0, 7, 0);
      check("sim_first_data", word_data, 8'h12);
      send_bits(8'h34, 0, 6, 0);
      check("sim_hold_data", word_data, 8'h12);
      word_ready = 1'b1;
      send_bits(8'h34, 7, 7, 0);
      word_ready = 1'b0;
      check("sim_data", word_data, 8'h34);
      check("sim_valid", word_valid, 1);
      check("sim_overrun", overrun, 0);
      word_ready = 1'b1;
      step();
      check("sim_drain", word_valid, 0);

      // Back-to-back frames
      send_bits(8'h5A, 0, 7, 0);
      check("b2b_first", word_data, 8'h5A);
      send_bits(8'hC3, 0, 7, 0);
      check("b2b_second", word_data, 8'hC3);
      check("b2b_valid", word_valid, 1);
      check("b2b_overrun", overrun, 0);

      // Reset mid-frame with a held word and a pending frame error
      word_ready = 1'b0;
      step();
      send_bits(8'h55, 0, 7, 0);
      send_bits(8'hFF, 0, 2, 0);
      send_bits(8'hFF, 0, 4, 0);
      check("mid_frame_err", frame_err, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_data", word_data, 0);
      check("mid_rst_valid", word_valid, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_frame_err", frame_err, 0);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      repeat (3) step();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      check("stray_valid", word_valid, 0);
      word_ready = 1'b1;
      send_bits(8'h81, 0, 7, 0);
      check("after_rst_valid", word_valid, 1);
      check("after_rst_data", word_data, 8'h81);
      check("after_rst_frame_err", frame_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
